img_buf_loader: RTL
===================

IMG_BUF_LOADER -- requirements
Module: img_buf_loader

Interface
REQ-001 SHALL have parameter TOTALSIZE, default 217984, meaning the pixel words per frame (524x416).
REQ-002 SHALL have parameter ADDR_W, default 19, meaning the buffer address width.
REQ-003 SHALL have port clk  in  1  sole clock, with all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port sof  in  1  start-of-frame, a synchronous restart.
REQ-006 SHALL have port s_valid  in  1  byte-stream valid.
REQ-007 SHALL have port s_data  in  8  stream byte.
REQ-008 SHALL have port s_ready  out  1  stream ready.
REQ-009 SHALL have port buf_en  out  1  buffer port enable.
REQ-010 SHALL have port buf_we  out  4  buffer byte write enables.
REQ-011 SHALL have port buf_addr  out  ADDR_W  buffer word address.
REQ-012 SHALL have port buf_din  out  32  buffer write data.
REQ-013 SHALL have port frame_done  out  1  one-cycle pulse after the last word is written.
REQ-014 SHALL have port busy  out  1  frame load in progress.

Function
REQ-015 SHALL accept a byte only on a cycle with s_valid=1 and s_ready=1.
REQ-016 SHALL pack four accepted bytes into one word: byte0->[31:24] R, byte1->[23:16] G, byte2->[15:8] B, byte3->[7:0] A.
REQ-017 SHALL implement the FSM states COLLECT, WRITE and DONE.
REQ-018 SHALL make s_ready high only in COLLECT, decoded combinationally from the state.
REQ-019 SHALL have COLLECT go to WRITE on the cycle after the 4th byte is accepted; SHALL stay in COLLECT otherwise.
REQ-020 SHALL, in WRITE, drive buf_en=1 and buf_we=4'hF for exactly one cycle, with buf_addr equal to the current word index and buf_din equal to the packed word.
REQ-021 SHALL drive buf_en=0, buf_we=4'h0 and buf_din=0 in all cycles other than WRITE.
REQ-022 SHALL, when WRITE completes at index < TOTALSIZE-1, increment the index and return to COLLECT.
REQ-023 SHALL, when WRITE completes at index TOTALSIZE-1, go to DONE and wrap the index to 0.
REQ-024 SHALL, in DONE, assert frame_done for one cycle and go to COLLECT on the next cycle.
REQ-025 SHALL set the minimum per-word period to 5 cycles (4 accepts + 1 write), and 6 cycles for the last word.
REQ-026 SHALL assert busy from the first byte accepted after reset/sof/DONE, and deassert it in the DONE cycle.
REQ-027 SHALL give sof priority over all other activity: the byte counter and word index go to 0, the state goes to COLLECT, and any pending WRITE is dropped (no buf_we).
REQ-028 SHALL, when sof and an accepted byte occur in the same cycle, take that byte as byte0 of word 0.
REQ-029 SHALL not raise frame_done for a partial frame, whether aborted by sof or by reset.

Reset
REQ-030 SHALL, while rst=1, force the state to COLLECT, the byte counter and word index to 0, and buf_en, buf_we, buf_din, frame_done and busy to 0.
REQ-031 SHALL drive s_ready=1 during and after reset.
REQ-032 SHALL, if rst asserts mid-frame, abandon the partial frame with no further write.

Configuration
REQ-033 SHALL, with IMG_BUF_LOADER_CHECKSUM_EN defined, add output checksum (8 bits) holding the mod-256 sum of all bytes of the last completed frame.
REQ-034 SHALL, with IMG_BUF_LOADER_CHECKSUM_EN defined, update checksum in the DONE cycle, clear it on rst, and reset the running sum on sof.
REQ-035 SHALL, without IMG_BUF_LOADER_CHECKSUM_EN, include no checksum port or logic, with all other behaviour identical.

Structure
REQ-036 SHALL place the frame constants (WIDTH=524, HEIGHT=416, TOTALSIZE, ADDR_W) and the FSM state encoding in shared package vga_pkg, which the display path uses as well.
REQ-037 SHALL implement the byte-to-word assembly as sub-module px_packer (byte counter + shift register, reporting word-complete).

Verification
REQ-038 SHALL cover: rst pulse -> s_ready=1, buf_we=0, busy=0, frame_done=0.
REQ-039 SHALL cover: bytes 12,34,56,78 (hex) with s_valid held high -> one write cycle with buf_addr=0, buf_din=32'h12345678, buf_we=4'hF; s_ready low for that cycle.
REQ-040 SHALL cover: a full frame of 871936 bytes -> exactly TOTALSIZE writes, addresses 0..217983, then one frame_done pulse and buf_addr wrapping to 0.
REQ-041 SHALL cover: sof after 2 bytes of word 5 -> no write, and the next 4 bytes are written at address 0.
REQ-042 SHALL cover: s_valid toggled randomly -> data and address are unchanged versus continuous valid, with no byte lost or duplicated.
REQ-043 SHALL cover, with IMG_BUF_LOADER_CHECKSUM_EN defined: a frame of all 8'h01 bytes -> checksum = 871936 mod 256 = 8'h00, and a frame with the first byte 8'h05 and the rest 8'h01 -> 8'h04.

Source files
------------

// File: rtl/vga_pkg.sv
// Frame geometry and loader FSM encoding shared by the buffer loader and the display path.
// The loader's optional checksum is enabled by defining IMG_BUF_LOADER_CHECKSUM_EN.
package vga_pkg;

    localparam int WIDTH     = 524;
    localparam int HEIGHT    = 416;
    localparam int TOTALSIZE = WIDTH * HEIGHT;
    localparam int ADDR_W    = 19;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_WRITE   = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/img_buf_loader_if.sv
// Stream-in / buffer-out bundle for img_buf_loader; the checksum member exists only
// when IMG_BUF_LOADER_CHECKSUM_EN is defined.
interface img_buf_loader_if #(
    parameter int ADDR_W = 19
);
    logic              sof;
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              buf_en;
    logic [3:0]        buf_we;
    logic [ADDR_W-1:0] buf_addr;
    logic [31:0]       buf_din;
    logic              frame_done;
    logic              busy;
`ifdef IMG_BUF_LOADER_CHECKSUM_EN
    logic [7:0]        checksum;

    modport master (
        output sof, s_valid, s_data,
        input  s_ready, buf_en, buf_we, buf_addr, buf_din, frame_done, busy, checksum
    );
    modport slave (
        input  sof, s_valid, s_data,
        output s_ready, buf_en, buf_we, buf_addr, buf_din, frame_done, busy, checksum
    );
`else
    modport master (
        output sof, s_valid, s_data,
        input  s_ready, buf_en, buf_we, buf_addr, buf_din, frame_done, busy
    );
    modport slave (
        input  sof, s_valid, s_data,
        output s_ready, buf_en, buf_we, buf_addr, buf_din, frame_done, busy
    );
`endif
endinterface

// File: rtl/img_buf_loader_px_packer.sv
// Byte-to-word assembler: counts accepted bytes and shifts them in, first byte ending up in [31:24].
// word_done_o flags the accept that completes a word; word_o is the word including that byte.
module px_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        take_i,
    input  logic [7:0]  byte_i,
    output logic        word_done_o,
    output logic [31:0] word_o
);
    logic [1:0]  cnt_q;
    logic [23:0] shift_q;

    assign word_o      = {shift_q, byte_i};
    assign word_done_o = take_i && !clr_i && (cnt_q == 2'd3);

    // A byte taken together with a clear becomes byte0 of the new word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= 2'd0;
            shift_q <= '0;
        end else begin
            if (clr_i) begin
                cnt_q <= take_i ? 2'd1 : 2'd0;
            end else if (take_i) begin
                cnt_q <= cnt_q + 2'd1;
            end
            if (take_i) begin
                shift_q <= word_o[23:0];
            end
        end
    end

endmodule

// File: rtl/img_buf_loader.sv
// Loads a byte stream into a word-wide frame buffer, one RGBA word per four bytes.
// Defining IMG_BUF_LOADER_CHECKSUM_EN adds an 8-bit sum of the last completed frame.
module img_buf_loader #(
    parameter int TOTALSIZE = vga_pkg::TOTALSIZE,
    parameter int ADDR_W    = vga_pkg::ADDR_W
) (
    input  logic            clk,
    input  logic            rst,
    img_buf_loader_if.slave bus
);
    import vga_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TOTALSIZE - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic              buf_en_q;
    logic [3:0]        buf_we_q;
    logic [31:0]       buf_din_q;
    logic              frame_done_q;
    logic              busy_q;
    logic              take;
    logic              word_done;
    logic [31:0]       word_d;

    assign bus.s_ready = (state_q == ST_COLLECT);
    assign take        = bus.s_valid && bus.s_ready;

    px_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (bus.sof),
        .take_i     (take),
        .byte_i     (bus.s_data),
        .word_done_o(word_done),
        .word_o     (word_d)
    );

    // sof wins over everything, including a word completing in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_COLLECT;
            idx_q        <= '0;
            buf_en_q     <= 1'b0;
            buf_we_q     <= 4'h0;
            buf_din_q    <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else if (bus.sof) begin
            state_q      <= ST_COLLECT;
            idx_q        <= '0;
            buf_en_q     <= 1'b0;
            buf_we_q     <= 4'h0;
            buf_din_q    <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= take;
        end else begin
            case (state_q)
                ST_COLLECT: begin
                    if (take) begin
                        busy_q <= 1'b1;
                    end
                    if (word_done) begin
                        state_q   <= ST_WRITE;
                        buf_en_q  <= 1'b1;
                        buf_we_q  <= 4'hF;
                        buf_din_q <= word_d;
                    end
                end
                ST_WRITE: begin
                    buf_en_q  <= 1'b0;
                    buf_we_q  <= 4'h0;
                    buf_din_q <= '0;
                    if (idx_q == LAST_IDX) begin
                        state_q      <= ST_DONE;
                        idx_q        <= '0;
                        frame_done_q <= 1'b1;
                        busy_q       <= 1'b0;
                    end else begin
                        state_q <= ST_COLLECT;
                        idx_q   <= idx_q + ADDR_W'(1);
                    end
                end
                ST_DONE: begin
                    frame_done_q <= 1'b0;
                    state_q      <= ST_COLLECT;
                end
                default: state_q <= ST_COLLECT;
            endcase
        end
    end

    assign bus.buf_en     = buf_en_q;
    assign bus.buf_we     = buf_we_q;
    assign bus.buf_addr   = idx_q;
    assign bus.buf_din    = buf_din_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = busy_q;

`ifdef IMG_BUF_LOADER_CHECKSUM_EN
    logic [7:0] sum_q;
    logic [7:0] checksum_q;

    // Snapshot lands on the edge into DONE, so it is already visible during frame_done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q      <= '0;
            checksum_q <= '0;
        end else if (bus.sof) begin
            sum_q <= take ? bus.s_data : 8'h00;
        end else if (state_q == ST_WRITE && idx_q == LAST_IDX) begin
            checksum_q <= sum_q;
            sum_q      <= '0;
        end else if (take) begin
            sum_q <= sum_q + bus.s_data;
        end
    end

    assign bus.checksum = checksum_q;
`endif

endmodule
